// File: rtl/mealy_lab_pkg.sv
// Shared types and helpers for the Mealy detector run sequencer.
package mealy_lab_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (priority) and count enable.
module sat_counter
  import mealy_lab_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = CNT_W'(sat_inc(32'(count), 32'(CntMax)));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/mealy_run_sequencer.sv
// Drives a latched pattern serially into two Mealy detectors and counts their hits.
// Define MEALY_SEQ_CMP_EN to enable detector B counting and A/B mismatch capture.
module mealy_run_sequencer
  import mealy_lab_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 5,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             z_a,
  input  logic             z_b,
  output logic             x,
  output logic             det_clear,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b,
  output logic             mismatch,
  output logic [LEN_W-1:0] mismatch_idx
);

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d, shifted;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d;
  logic             x_d, det_clear_d, busy_d, done_d;
  logic             load_cyc, run_cyc;

  assign load_cyc = (state_q == StLoad);
  assign run_cyc  = (state_q == StRun);

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    idx_d     = idx_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLoad;
          pattern_d = pattern;
          len_d     = (len > MaxLen) ? MaxLen : len;
          idx_d     = '0;
        end
      end
      StLoad: state_d = (len_q != '0) ? StRun : StDone;
      StRun: begin
        idx_d = idx_q + LEN_W'(1);
        if (idx_q == len_q - LEN_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    shifted     = pattern_d >> idx_d;
    x_d         = (state_d == StRun) & shifted[0];
    det_clear_d = (state_d == StLoad);
    busy_d      = (state_d == StLoad) || (state_d == StRun);
    done_d      = (state_d == StDone);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      x         <= 1'b0;
      det_clear <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      x         <= x_d;
      det_clear <= det_clear_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_a (
    .clock(clock),
    .reset(reset),
    .clear(load_cyc),
    .en   (run_cyc & z_a),
    .count(count_a)
  );

`ifdef MEALY_SEQ_CMP_EN
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt_b (
    .clock(clock),
    .reset(reset),
    .clear(load_cyc),
    .en   (run_cyc & z_b),
    .count(count_b)
  );

  // Only the first disagreement of a run is recorded.
  always_ff @(posedge clock) begin
    if (reset || load_cyc) begin
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
    end else if (run_cyc && (z_a != z_b) && !mismatch) begin
      mismatch     <= 1'b1;
      mismatch_idx <= idx_q;
    end
  end
`else
  logic unused_z_b;
  assign unused_z_b   = z_b;
  assign count_b      = '0;
  assign mismatch     = 1'b0;
  assign mismatch_idx = '0;
`endif

endmodule

// File: tb/tb_mealy_run_sequencer.sv
// Directed bench for mealy_run_sequencer; detector A is modelled as z_a = x.
module tb_mealy_run_sequencer;

`ifdef MEALY_SEQ_CMP_EN
  localparam bit Cmp = 1'b1;
`else
  localparam bit Cmp = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic        zb_inv;
  logic        z_a, z_b;
  logic        x, det_clear, busy, done, mismatch;
  logic [4:0]  count_a, count_b, mismatch_idx;

  logic        sat_x;
  logic [2:0]  sat_count_a;
  logic        unused_s_clr, unused_s_busy, unused_s_done, unused_s_mm;
  logic [2:0]  unused_s_cb;
  logic [4:0]  unused_s_idx;

  int errors = 0;
  int checks = 0;

  int lat, busy_cyc, clr_cyc, done_cnt, post_rst;

  assign z_a = x;
  assign z_b = zb_inv ? ~x : 1'b0;

  mealy_run_sequencer u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pattern     (pattern),
    .len         (len),
    .z_a         (z_a),
    .z_b         (z_b),
    .x           (x),
    .det_clear   (det_clear),
    .busy        (busy),
    .done        (done),
    .count_a     (count_a),
    .count_b     (count_b),
    .mismatch    (mismatch),
    .mismatch_idx(mismatch_idx)
  );

  // Narrow counters to exercise saturation.
  mealy_run_sequencer #(
    .CNT_W(3)
  ) u_sat (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .pattern     (pattern),
    .len         (len),
    .z_a         (sat_x),
    .z_b         (1'b0),
    .x           (sat_x),
    .det_clear   (unused_s_clr),
    .busy        (unused_s_busy),
    .done        (unused_s_done),
    .count_a     (sat_count_a),
    .count_b     (unused_s_cb),
    .mismatch    (unused_s_mm),
    .mismatch_idx(unused_s_idx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Cycle c=1 is the cycle right after the start edge; done is expected at c=len+2.
  task automatic run_seq(input logic [15:0] p, input logic [4:0] l, input int pulse_at,
                         input int rst_at);
    @(negedge clock);
    pattern = p;
    len     = l;
    start   = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    lat      = 0;
    busy_cyc = 0;
    clr_cyc  = 0;
    done_cnt = 0;
    post_rst = -1;
    for (int c = 1; c <= 40; c++) begin
      if (busy) busy_cyc++;
      if (det_clear) clr_cyc++;
      if (done) begin
        done_cnt++;
        if (lat == 0) lat = c;
      end
      if (c == rst_at + 1) begin
        post_rst = int'({x, det_clear, busy, done, mismatch}) + int'(count_a) +
                   int'(count_b) + int'(mismatch_idx);
      end
      start = (c == pulse_at);
      reset = (c == rst_at);
      @(negedge clock);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
    zb_inv  = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_outs", int'({x, det_clear, busy, done, mismatch}), 0);
    check("rst_cnts", int'(count_a) + int'(count_b) + int'(mismatch_idx), 0);
    reset = 1'b0;

    // A5A5 over 16 bits: 8 ones, first bit is 1 so B (=0) disagrees at index 0.
    run_seq(16'hA5A5, 5'd16, 0, 0);
    check("a5_lat", lat, 18);
    check("a5_busy", busy_cyc, 17);
    check("a5_clr", clr_cyc, 1);
    check("a5_done_cnt", done_cnt, 1);
    check("a5_cnt_a", int'(count_a), 8);
    check("a5_mm", int'(mismatch), Cmp ? 1 : 0);
    check("a5_mm_idx", int'(mismatch_idx), 0);

    // 0014 over 8 bits: ones at bits 2 and 4.
    run_seq(16'h0014, 5'd8, 0, 0);
    check("14_lat", lat, 10);
    check("14_cnt_a", int'(count_a), 2);
    check("14_cnt_b", int'(count_b), 0);
    check("14_mm", int'(mismatch), Cmp ? 1 : 0);
    check("14_mm_idx", int'(mismatch_idx), Cmp ? 2 : 0);

    run_seq(16'hFFFF, 5'd0, 0, 0);
    check("len0_lat", lat, 2);
    check("len0_busy", busy_cyc, 1);
    check("len0_clr", clr_cyc, 1);
    check("len0_cnt_a", int'(count_a), 0);
    check("len0_mm", int'(mismatch), 0);

    run_seq(16'hA5A5, 5'd20, 0, 0);
    check("len20_lat", lat, 18);
    check("len20_busy", busy_cyc, 17);
    check("len20_cnt_a", int'(count_a), 8);

    run_seq(16'hFFFF, 5'd16, 0, 0);
    check("ff_cnt_a", int'(count_a), 16);
    check("ff_sat_cnt", int'(sat_count_a), 7);

    // start pulse mid-RUN is dropped.
    run_seq(16'hA5A5, 5'd16, 5, 0);
    check("pulse_done_cnt", done_cnt, 1);
    check("pulse_lat", lat, 18);
    check("pulse_cnt_a", int'(count_a), 8);

    // Reset while bit 5 is on x (cycle 7).
    run_seq(16'hFFFF, 5'd16, 0, 7);
    check("abort_outs", post_rst, 0);
    check("abort_done_cnt", done_cnt, 0);

    run_seq(16'h0014, 5'd8, 0, 0);
    check("after_lat", lat, 10);
    check("after_cnt_a", int'(count_a), 2);

    // B = ~x: six ones over 0014/8, disagreement from bit 0.
    zb_inv = 1'b1;
    run_seq(16'h0014, 5'd8, 0, 0);
    check("inv_cnt_a", int'(count_a), 2);
    check("inv_cnt_b", int'(count_b), Cmp ? 6 : 0);
    check("inv_mm", int'(mismatch), Cmp ? 1 : 0);
    check("inv_mm_idx", int'(mismatch_idx), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
